// File: rtl/watch_pkg.sv
// Shared encodings for the watch time-set sequencer: main/repeat state
// enums and the one-hot field-select constants with rotation helpers.
package watch_pkg;

  typedef enum logic {
    RUN = 1'b0,
    SET = 1'b1
  } main_state_t;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_DELAY  = 2'd1,
    R_REPEAT = 2'd2
  } rep_state_t;

  localparam logic [2:0] FLD_NONE = 3'b000;
  localparam logic [2:0] FLD_SEC  = 3'b001;
  localparam logic [2:0] FLD_MIN  = 3'b010;
  localparam logic [2:0] FLD_HOUR = 3'b100;

  // sec -> min -> hour -> sec
  function automatic logic [2:0] fld_next(input logic [2:0] f);
    return {f[1:0], f[2]};
  endfunction

  // sec -> hour -> min -> sec
  function automatic logic [2:0] fld_prev(input logic [2:0] f);
    return {f[0], f[2:1]};
  endfunction

endpackage

// File: rtl/watch_set_ctrl_key_repeat.sv
// One key's edge detector plus hold-delay / auto-repeat pulse generator.
// A pulse fires on the rising edge, again after HOLD_CYC, then every REPEAT_CYC.
module key_repeat
  import watch_pkg::*;
#(
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic key,
  input  logic clr,
  output logic pulse
);

  localparam int MAX_CYC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  rep_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             key_p1;
  logic             pulse_nx;
  logic             rise;

  assign rise = key & ~key_p1;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pulse_nx = 1'b0;
    if (!en || clr) begin
      state_nx = R_IDLE;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        R_IDLE: begin
          if (rise) begin
            state_nx = R_DELAY;
            cnt_nx   = '0;
            pulse_nx = 1'b1;
          end
        end
        R_DELAY: begin
          if (!key) begin
            state_nx = R_IDLE;
            cnt_nx   = '0;
          end else if (cnt == CNT_W'(HOLD_CYC - 1)) begin
            state_nx = R_REPEAT;
            cnt_nx   = '0;
            pulse_nx = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        R_REPEAT: begin
          if (!key) begin
            state_nx = R_IDLE;
            cnt_nx   = '0;
          end else if (cnt == CNT_W'(REPEAT_CYC - 1)) begin
            cnt_nx   = '0;
            pulse_nx = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = R_IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= R_IDLE;
      cnt    <= '0;
      pulse  <= 1'b0;
      key_p1 <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      pulse  <= pulse_nx;
      key_p1 <= key;
    end
  end

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-set sequencer: RUN/SET mode control, field rotation, inc/dec
// auto-repeat strobes, inactivity timeout with re-entry lock, and blink.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int HOLD_CYC    = 50_000_000,
  parameter int REPEAT_CYC  = 10_000_000,
  parameter int TIMEOUT_CYC = 1_000_000_000,
  parameter int BLINK_CYC   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       set_mode,
  output logic       stop,
  output logic [2:0] field_sel,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       blink
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int BL_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  logic set_en_p0, next_p0, prev_p0, up_p0, down_p0;
  logic next_p1, prev_p1, up_p1, down_p1;

  main_state_t       state, state_nx;
  logic              lock, lock_nx;
  logic [TO_W-1:0]   idle_cnt, idle_nx;
  logic [BL_W-1:0]   blink_cnt, blink_cnt_nx;
  logic              blink_nx;
  logic [2:0]        field_nx;
  logic              rep_clr;
  logic              in_set;
  logic              next_rise, prev_rise, up_rise, down_rise, any_rise;

  assign next_rise = next_p0 & ~next_p1;
  assign prev_rise = prev_p0 & ~prev_p1;
  assign up_rise   = up_p0 & ~up_p1;
  assign down_rise = down_p0 & ~down_p1;
  assign any_rise  = next_rise | prev_rise | up_rise | down_rise;
  assign in_set    = (state == SET);
  assign set_mode  = in_set;
  assign stop      = in_set;

  always_comb begin
    state_nx     = state;
    lock_nx      = lock;
    idle_nx      = idle_cnt;
    blink_nx     = blink;
    blink_cnt_nx = blink_cnt;
    field_nx     = field_sel;
    rep_clr      = 1'b0;
    if (!set_en_p0) lock_nx = 1'b0;
    if (state == RUN) begin
      idle_nx      = '0;
      blink_nx     = 1'b0;
      blink_cnt_nx = '0;
      field_nx     = FLD_NONE;
      if (set_en_p0 && !lock) begin
        state_nx = SET;
        field_nx = FLD_SEC;
        blink_nx = 1'b1;
      end
    end else if (!set_en_p0 || idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
      // Exit wins over everything; a timeout exit locks until set_en drops.
      state_nx     = RUN;
      lock_nx      = set_en_p0;
      field_nx     = FLD_NONE;
      idle_nx      = '0;
      blink_nx     = 1'b0;
      blink_cnt_nx = '0;
      rep_clr      = 1'b1;
    end else begin
      if (any_rise || inc_pulse || dec_pulse) idle_nx = '0;
      else                                     idle_nx = idle_cnt + 1'b1;
      if (next_rise && !prev_rise) begin
        field_nx = fld_next(field_sel);
        rep_clr  = 1'b1;
      end else if (prev_rise && !next_rise) begin
        field_nx = fld_prev(field_sel);
        rep_clr  = 1'b1;
      end
      if (up_p0 && down_p0) rep_clr = 1'b1;
      if (blink_cnt == BL_W'(BLINK_CYC - 1)) begin
        blink_nx     = ~blink;
        blink_cnt_nx = '0;
      end else begin
        blink_cnt_nx = blink_cnt + 1'b1;
      end
    end
  end

  // Input sampling stage (p0) and edge-history stage (p1), then control state
  always_ff @(posedge clk) begin
    if (!rst) begin
      set_en_p0 <= 1'b0;
      next_p0   <= 1'b0;
      prev_p0   <= 1'b0;
      up_p0     <= 1'b0;
      down_p0   <= 1'b0;
      next_p1   <= 1'b0;
      prev_p1   <= 1'b0;
      up_p1     <= 1'b0;
      down_p1   <= 1'b0;
      state     <= RUN;
      lock      <= 1'b0;
      idle_cnt  <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
      field_sel <= FLD_NONE;
    end else begin
      set_en_p0 <= set_en;
      next_p0   <= btn_next;
      prev_p0   <= btn_prev;
      up_p0     <= btn_up;
      down_p0   <= btn_down;
      next_p1   <= next_p0;
      prev_p1   <= prev_p0;
      up_p1     <= up_p0;
      down_p1   <= down_p0;
      state     <= state_nx;
      lock      <= lock_nx;
      idle_cnt  <= idle_nx;
      blink_cnt <= blink_cnt_nx;
      blink     <= blink_nx;
      field_sel <= field_nx;
    end
  end

  key_repeat #(
    .HOLD_CYC  (HOLD_CYC),
    .REPEAT_CYC(REPEAT_CYC)
  ) u_up (
    .clk  (clk),
    .rst  (rst),
    .en   (in_set),
    .key  (up_p0),
    .clr  (rep_clr),
    .pulse(inc_pulse)
  );

  key_repeat #(
    .HOLD_CYC  (HOLD_CYC),
    .REPEAT_CYC(REPEAT_CYC)
  ) u_down (
    .clk  (clk),
    .rst  (rst),
    .en   (in_set),
    .key  (down_p0),
    .clr  (rep_clr),
    .pulse(dec_pulse)
  );

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Self-checking bench for watch_set_ctrl: directed scenarios plus random
// stimulus, all compared against a behavioural model of the set sequencer.
module tb_watch_set_ctrl;

  localparam int H = 8;
  localparam int R = 4;
  localparam int T = 64;
  localparam int B = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic set_en = 1'b0;
  logic btn_next = 1'b0, btn_prev = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic set_mode, stop, inc_pulse, dec_pulse, blink;
  logic [2:0] field_sel;
  logic [7:0] obs;

  int total = 0;
  int bad   = 0;

  watch_set_ctrl #(
    .HOLD_CYC(H), .REPEAT_CYC(R), .TIMEOUT_CYC(T), .BLINK_CYC(B)
  ) dut (
    .clk(clk), .rst(rst), .set_en(set_en),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_up(btn_up), .btn_down(btn_down),
    .set_mode(set_mode), .stop(stop), .field_sel(field_sel),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .blink(blink)
  );

  always #5 clk = ~clk;

  assign obs = {set_mode, stop, field_sel, inc_pulse, dec_pulse, blink};

  // Behavioural model: registered input levels, mode, field index (0=sec,
  // 1=min, 2=hour), idle count, cycles spent in SET, and per-key repeat runs
  // described by their start cycle.
  logic m_set, m_nx, m_pv, m_up, m_dn;
  logic m_nx_d, m_pv_d, m_up_d, m_dn_d;
  logic m_mode, m_lock, m_inc, m_dec, up_act, dn_act;
  int   m_fld, m_idle, m_since, up_start, dn_start, t;

  initial begin
    {m_set, m_nx, m_pv, m_up, m_dn, m_nx_d, m_pv_d, m_up_d, m_dn_d} = '0;
    {m_mode, m_lock, m_inc, m_dec, up_act, dn_act} = '0;
    m_fld = 0; m_idle = 0; m_since = 0; up_start = 0; dn_start = 0; t = 0;
  end

  task automatic model_step();
    logic nr, pr, ur, dr, fchg, both, n_inc, n_dec;
    int k;
    t++;
    if (!rst) begin
      {m_set, m_nx, m_pv, m_up, m_dn, m_nx_d, m_pv_d, m_up_d, m_dn_d} = '0;
      {m_mode, m_lock, m_inc, m_dec, up_act, dn_act} = '0;
      m_fld = 0; m_idle = 0; m_since = 0;
      return;
    end
    nr = m_nx & ~m_nx_d;
    pr = m_pv & ~m_pv_d;
    ur = m_up & ~m_up_d;
    dr = m_dn & ~m_dn_d;
    n_inc = 1'b0;
    n_dec = 1'b0;
    if (m_mode) begin
      if (!m_set || m_idle == T - 1) begin
        if (m_set) m_lock = 1'b1;
        m_mode = 1'b0; up_act = 1'b0; dn_act = 1'b0; m_idle = 0; m_since = 0;
      end else begin
        fchg = nr ^ pr;
        both = m_up & m_dn;
        if (nr && !pr) m_fld = (m_fld + 1) % 3;
        else if (pr && !nr) m_fld = (m_fld + 2) % 3;
        if (ur && !fchg && !both) begin up_act = 1'b1; up_start = t; end
        if (up_act && m_up && !fchg && !both) begin
          k = t - up_start;
          n_inc = (k == 0) || (k >= H && (k - H) % R == 0);
        end else up_act = 1'b0;
        if (dr && !fchg && !both) begin dn_act = 1'b1; dn_start = t; end
        if (dn_act && m_dn && !fchg && !both) begin
          k = t - dn_start;
          n_dec = (k == 0) || (k >= H && (k - H) % R == 0);
        end else dn_act = 1'b0;
        m_idle = (nr || pr || ur || dr || m_inc || m_dec) ? 0 : m_idle + 1;
        m_since++;
      end
    end else begin
      if (!m_set) m_lock = 1'b0;
      else if (!m_lock) begin m_mode = 1'b1; m_fld = 0; m_idle = 0; m_since = 0; end
    end
    m_inc = n_inc;
    m_dec = n_dec;
    m_nx_d = m_nx; m_pv_d = m_pv; m_up_d = m_up; m_dn_d = m_dn;
    m_set = set_en; m_nx = btn_next; m_pv = btn_prev; m_up = btn_up; m_dn = btn_down;
  endtask

  always @(posedge clk) model_step();

  function automatic logic [7:0] exp_vec();
    logic [2:0] f;
    logic       bl;
    f  = m_mode ? 3'(1 << m_fld) : 3'b000;
    bl = m_mode && ((m_since / B) % 2 == 0);
    return {m_mode, m_mode, f, m_inc, m_dec, bl};
  endfunction

  task automatic test_reset();
    rst = 1'b0; set_en = 1'b0;
    {btn_next, btn_prev, btn_up, btn_down} = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (obs !== 8'h00) begin
        bad++; $display("FAIL reset cyc=%0d got=%b want=%b", c, obs, 8'h00);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== exp_vec()) begin
      bad++; $display("FAIL reset_release got=%b want=%b", obs, exp_vec());
    end
  endtask

  task automatic test_enter_fields();
    logic [2:0] want [4];
    want = '{3'b010, 3'b100, 3'b001, 3'b100};
    set_en = 1'b1;
    @(negedge clk);
    total++;
    if (set_mode !== 1'b0) begin
      bad++; $display("FAIL enter_latency got=%b want=0", set_mode);
    end
    @(negedge clk);
    total++;
    if ({set_mode, stop, field_sel} !== 5'b11001) begin
      bad++; $display("FAIL enter got=%b want=11001", {set_mode, stop, field_sel});
    end
    for (int c = 0; c < 16; c++) begin
      btn_next = (c < 12) && (c % 4 < 2);
      btn_prev = (c >= 12) && (c % 4 < 2);
      @(negedge clk);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL fields_model cyc=%0d got=%b want=%b", c, obs, exp_vec());
      end
      if (c % 4 == 3) begin
        total++;
        if (field_sel !== want[c/4]) begin
          bad++; $display("FAIL field_rot step=%0d got=%b want=%b", c / 4, field_sel, want[c/4]);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] inc_m, dec_m, want_m;
    inc_m = '0; dec_m = '0; want_m = '0;
    want_m[1] = 1'b1; want_m[1+H] = 1'b1; want_m[1+H+R] = 1'b1; want_m[1+H+2*R] = 1'b1;
    for (int c = 0; c < 32; c++) begin
      btn_up = (c < 20);
      @(negedge clk);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL hold_model cyc=%0d got=%b want=%b", c, obs, exp_vec());
      end
      inc_m[c] = inc_pulse;
      dec_m[c] = dec_pulse;
    end
    total++;
    if (inc_m !== want_m) begin
      bad++; $display("FAIL hold_inc_cycles got=%h want=%h", inc_m, want_m);
    end
    total++;
    if (dec_m !== 32'h0) begin
      bad++; $display("FAIL hold_dec got=%h want=0", dec_m);
    end
  endtask

  task automatic test_both();
    int n_inc, n_dec;
    n_inc = 0; n_dec = 0;
    for (int c = 0; c < 24; c++) begin
      btn_up   = (c < 6);
      btn_down = (c < 6) || (c >= 10 && c < 13);
      @(negedge clk);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL both_model cyc=%0d got=%b want=%b", c, obs, exp_vec());
      end
      n_inc += int'(inc_pulse);
      n_dec += int'(dec_pulse);
    end
    total++;
    if (n_inc != 0 || n_dec != 1) begin
      bad++; $display("FAIL both_counts got=inc%0d/dec%0d want=inc0/dec1", n_inc, n_dec);
    end
  endtask

  task automatic test_timeout_lock();
    int  k;
    logic wb;
    k = 0;
    set_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL to_exit_model cyc=%0d got=%b want=%b", c, obs, exp_vec());
      end
    end
    for (int c = 0; c < 90; c++) begin
      set_en = 1'b1;
      @(negedge clk);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL to_model cyc=%0d got=%b want=%b", c, obs, exp_vec());
      end
      if (set_mode) begin
        wb = ((k / B) % 2 == 0);
        total++;
        if (blink !== wb) begin
          bad++; $display("FAIL blink k=%0d got=%b want=%b", k, blink, wb);
        end
        k++;
      end
    end
    total++;
    if (k != T) begin
      bad++; $display("FAIL timeout_len got=%0d want=%0d", k, T);
    end
    total++;
    if ({set_mode, field_sel} !== 4'b0000) begin
      bad++; $display("FAIL lock_hold got=%b want=0000", {set_mode, field_sel});
    end
    for (int c = 0; c < 4; c++) begin
      set_en = (c >= 2);
      @(negedge clk);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL reenter_model cyc=%0d got=%b want=%b", c, obs, exp_vec());
      end
    end
    total++;
    if ({set_mode, field_sel} !== 4'b1001) begin
      bad++; $display("FAIL reenter got=%b want=1001", {set_mode, field_sel});
    end
  endtask

  task automatic test_exit_in_repeat();
    int pre;
    pre = 0;
    for (int c = 0; c < 24; c++) begin
      btn_down = (c < 20);
      set_en   = (c < 14);
      @(negedge clk);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL exit_model cyc=%0d got=%b want=%b", c, obs, exp_vec());
      end
      if (c < 14) pre += int'(dec_pulse);
      else begin
        total++;
        if (dec_pulse !== 1'b0) begin
          bad++; $display("FAIL exit_dec cyc=%0d got=%b want=0", c, dec_pulse);
        end
      end
      if (c >= 15) begin
        total++;
        if (set_mode !== 1'b0) begin
          bad++; $display("FAIL exit_mode cyc=%0d got=%b want=0", c, set_mode);
        end
      end
    end
    total++;
    if (pre != 3) begin
      bad++; $display("FAIL exit_pre_pulses got=%0d want=3", pre);
    end
  endtask

  task automatic test_reset_mid();
    set_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL rmid_enter cyc=%0d got=%b want=%b", c, obs, exp_vec());
      end
    end
    for (int c = 0; c < 20; c++) begin
      btn_up = (c < 16);
      rst    = !(c == 11 || c == 12);
      @(negedge clk);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL rmid_model cyc=%0d got=%b want=%b", c, obs, exp_vec());
      end
      if (c == 11 || c == 12) begin
        total++;
        if (obs !== 8'h00) begin
          bad++; $display("FAIL rmid_zero cyc=%0d got=%b want=00000000", c, obs);
        end
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic quiet;
    for (int c = 0; c < 4000; c++) begin
      quiet = (c % 256) >= 150;
      rst = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 79) == 0) set_en = ~set_en;
      if (quiet) {btn_next, btn_prev, btn_up, btn_down} = '0;
      else begin
        if ($urandom_range(0, 9) == 0)  btn_next = ~btn_next;
        if ($urandom_range(0, 9) == 0)  btn_prev = ~btn_prev;
        if ($urandom_range(0, 13) == 0) btn_up   = ~btn_up;
        if ($urandom_range(0, 13) == 0) btn_down = ~btn_down;
      end
      @(negedge clk);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL random cyc=%0d got=%b want=%b", c, obs, exp_vec());
      end
      total++;
      if ((inc_pulse & dec_pulse) !== 1'b0) begin
        bad++; $display("FAIL random_excl cyc=%0d got=%b%b want=not both", c, inc_pulse, dec_pulse);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_enter_fields();
    test_hold();
    test_both();
    test_timeout_lock();
    test_exit_in_repeat();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/watch_set_ctrl.md
Name: watch_set_ctrl

Overview:
- Time-set sequencer for the watch datapath: while set mode is requested it freezes counting, selects the field to edit (sec/min/hour), and emits single-cycle inc/dec pulses.
- Held up/down keys auto-repeat. Set mode exits automatically after an inactivity timeout.
- Sits between the button debouncers and the watch datapath's stop/up/down/field-select inputs.

Parameters:
- HOLD_CYC, 50_000_000, cycles from the first pulse of a held key to the first repeat pulse.
- REPEAT_CYC, 10_000_000, cycles between repeat pulses.
- TIMEOUT_CYC, 1_000_000_000, idle cycles in set mode before forced exit (counter width 30 bits).
- BLINK_CYC, 25_000_000, half-period of the blink output.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- set_en  in  1  set-mode request level (switch)
- btn_next  in  1  debounced level; advance field
- btn_prev  in  1  debounced level; previous field
- btn_up  in  1  debounced level; increment selected field
- btn_down  in  1  debounced level; decrement selected field
- set_mode  out  1  1 while in SET
- stop  out  1  freeze datapath counting; equals set_mode
- field_sel  out  3  one-hot {hour,min,sec}; 3'b000 in RUN
- inc_pulse  out  1  one-cycle increment strobe
- dec_pulse  out  1  one-cycle decrement strobe
- blink  out  1  display blink enable for the selected field

Behaviour:
- Reset (rst==0 at a clk edge): state=RUN, set_mode=0, stop=0, field_sel=000, inc/dec_pulse=0, blink=0. All counters and edge registers clear; the lock flag clears.
- Inputs are registered once. A rising edge means current=1 and previous=0. Every output is registered.
- Main FSM:
  - RUN -> SET when set_en=1 and lock=0. On entry field_sel=001 (sec) and the timeout counter clears.
  - SET -> RUN when set_en=0. This takes priority over every other event. Any repeat in progress is aborted and no pulse is emitted that cycle.
  - SET -> RUN when the idle counter reaches TIMEOUT_CYC-1. lock is then set; lock clears only when set_en=0. Re-entry therefore needs set_en to fall and rise again.
- Field rotation, in SET only:
  - next edge: sec->min->hour->sec.
  - prev edge: the reverse order.
  - next and prev edges in the same cycle: both ignored.
- Inc/dec repeat sub-FSM (R_IDLE, R_DELAY, R_REPEAT), SET only:
  - Up edge sampled in cycle N -> inc_pulse=1 in cycle N+1; enter R_DELAY.
  - Key still held -> further pulses at N+1+HOLD_CYC, then every REPEAT_CYC (R_REPEAT).
  - Key release -> R_IDLE immediately; no further pulse.
  - btn_down is symmetric and drives dec_pulse.
  - up and down both high (edge or hold): no pulses, R_IDLE. Resume only on a fresh edge after release.
  - A field change while a key is held ends the repeat (R_IDLE); a new edge is required.
  - inc_pulse and dec_pulse are never both 1.
- Idle timeout counter clears on any rising edge of any button and on every emitted pulse. Otherwise it increments in SET and is held at 0 in RUN.
- blink toggles every BLINK_CYC cycles in SET. It is forced to 0 in RUN and restarts at 1 on SET entry.
- Reset mid-operation (mid-repeat or in SET) returns everything to reset values on the next edge with no stray pulse.

Decomposition:
- Package watch_pkg holds:
  - main state encoding (RUN, SET)
  - repeat state encoding (R_IDLE, R_DELAY, R_REPEAT)
  - field one-hot constants FLD_SEC=001, FLD_MIN=010, FLD_HOUR=100
- Sub-module key_repeat: edge detect plus delay/repeat counter for one key.
  - Ports: clk, rst, en, key, clr, pulse.
  - Instantiated twice (up, down). The top applies mutual exclusion and clears on field change or exit.

Test Plan (HOLD_CYC=8, REPEAT_CYC=4, TIMEOUT_CYC=64, BLINK_CYC=16):
- Release reset, set_en=1 -> set_mode=1, stop=1, field_sel=001 one cycle after the registered sample. Three next edges -> 010, 100, 001. One prev edge -> 100.
- In SET, btn_up held 20 cycles from the edge in cycle N -> inc_pulse at N+1, N+9, N+13, N+17 only. dec_pulse stays 0.
- btn_up and btn_down rise in the same cycle -> no pulses. Release both, then a down edge -> exactly one dec_pulse.
- set_en=1 with no buttons for 64 cycles -> set_mode=0, field_sel=000. set_en held at 1 stays in RUN. Toggle set_en 0->1 -> SET re-entered with field 001.
- btn_down held, set_en dropped during R_REPEAT -> RUN next cycle; no dec_pulse from that cycle on.
- rst=0 asserted mid-repeat -> all outputs 0 at the next clk edge. Check blink period: 16 cycles high, 16 low in SET.
